axis_pkt_source: RTL and testbench

//  AXI4-Stream packet transmitter with HLS-style block-level control (ap_start/ap_done/ap_idle/ap_ready).

---
 rtl/axis_pkt_source_if.sv | 15 +
 rtl/axis_pkt_source.sv | 139 +++++++++++++
 tb/tb_axis_pkt_source.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pkt_source_if.sv
// AXI4-Stream bundle carrying one packet source to its sink.
// The master drives beats and the slave returns TREADY.
interface axis_pkt_source_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   TDATA;
  logic                TVALID;
  logic                TREADY;
  logic [DATA_W/8-1:0] TKEEP;
  logic [DATA_W/8-1:0] TSTRB;
  logic                TLAST;

  modport master (output TDATA, TVALID, TKEEP, TSTRB, TLAST, input TREADY);
  modport slave  (input TDATA, TVALID, TKEEP, TSTRB, TLAST, output TREADY);
endinterface

// File: rtl/axis_pkt_source.sv
// AXI4-Stream packet source with ap_start/ap_done/ap_idle/ap_ready control.
// Each start emits ceil(byte_count/KB) beats of incrementing data from seed.
module axis_pkt_source #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [LEN_W-1:0]  byte_count,
  input  logic [DATA_W-1:0] seed,
  axis_pkt_source_if.master M,
  output logic [LEN_W-1:0]  pkt_count
);
  localparam int KB = DATA_W / 8;
  localparam logic [LEN_W-1:0] KB_L = LEN_W'(KB);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tdata_q;
  logic              tvalid_q;
  logic [KB-1:0]     tkeep_q;
  logic              tlast_q;
  logic [LEN_W-1:0]  beat_idx_q;
  logic [LEN_W-1:0]  last_idx_q;
  logic [LEN_W-1:0]  rem_q;
  logic [LEN_W-1:0]  pkt_count_q;

  logic [LEN_W-1:0]  nbeats_in;
  logic [LEN_W-1:0]  rem_in;
  logic [LEN_W-1:0]  next_idx;
  logic              hs;
  logic              load_first;
  logic              load_next;
  logic              finish;

  // Byte qualifier of the final beat: low rem bytes, or all bytes when rem is 0.
  function automatic logic [KB-1:0] last_keep(input logic [LEN_W-1:0] rem);
    logic [KB-1:0] k;
    for (int i = 0; i < KB; i++)
      k[i] = (rem == '0) || (LEN_W'(i) < rem);
    return k;
  endfunction

  assign rem_in    = byte_count % KB_L;
  assign nbeats_in = (byte_count / KB_L) + LEN_W'(rem_in != '0);
  assign next_idx  = beat_idx_q + LEN_W'(1);
  assign hs        = tvalid_q & M.TREADY;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ap_idle    = 1'b0;
    ap_ready   = 1'b0;
    ap_done    = 1'b0;
    load_first = 1'b0;
    load_next  = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          ap_ready = 1'b1;
          if (byte_count != '0) begin
            load_first = 1'b1;
            state_d    = SEND;
          end else begin
            state_d    = DONE;
          end
        end
      end
      SEND: begin
        if (hs) begin
          if (tlast_q) begin
            finish  = 1'b1;
            state_d = DONE;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      DONE: begin
        ap_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat register: loads the next beat in the same edge as the handshake.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      beat_idx_q  <= '0;
      last_idx_q  <= '0;
      rem_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      if (load_first) begin
        last_idx_q <= nbeats_in - LEN_W'(1);
        rem_q      <= rem_in;
        beat_idx_q <= '0;
        tdata_q    <= seed;
        tvalid_q   <= 1'b1;
        tlast_q    <= (nbeats_in == LEN_W'(1));
        tkeep_q    <= (nbeats_in == LEN_W'(1)) ? last_keep(rem_in) : '1;
      end else if (load_next) begin
        beat_idx_q <= next_idx;
        tdata_q    <= tdata_q + DATA_W'(1);
        tlast_q    <= (next_idx == last_idx_q);
        tkeep_q    <= (next_idx == last_idx_q) ? last_keep(rem_q) : '1;
      end else if (finish) begin
        tvalid_q   <= 1'b0;
        tlast_q    <= 1'b0;
        tkeep_q    <= '0;
      end
      if (state_q == DONE)
        pkt_count_q <= pkt_count_q + LEN_W'(1);
    end
  end

  assign M.TDATA   = tdata_q;
  assign M.TVALID  = tvalid_q;
  assign M.TKEEP   = tkeep_q;
  assign M.TSTRB   = tkeep_q;
  assign M.TLAST   = tlast_q;
  assign pkt_count = pkt_count_q;
endmodule

// File: tb/tb_axis_pkt_source.sv
// Randomized self-checking bench for axis_pkt_source against a packet-level model.
module tb_axis_pkt_source;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic        last;
    int          cyc;
  } beat_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [15:0] byte_count;
  logic [31:0] seed;
  logic [15:0] pkt_count;

  axis_pkt_source_if #(.DATA_W(DATA_W)) m_if ();

  axis_pkt_source #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .byte_count (byte_count),
    .seed       (seed),
    .M          (m_if),
    .pkt_count  (pkt_count)
  );

  always #5 ap_clk = ~ap_clk;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          tr_mode = 0;
  int          tr_idx = 0;
  bit          any_valid = 0;
  logic [15:0] exp_pkts = 16'd0;
  beat_t       obs_q[$];
  beat_t       exp_q[$];
  int          done_q[$];
  int          ready_q[$];

  // Sink ready pattern: 0 always ready, 1 repeating 1,0,0, 2 random.
  initial begin
    m_if.TREADY = 1'b1;
    forever begin
      @(posedge ap_clk); #1;
      case (tr_mode)
        0:       m_if.TREADY = 1'b1;
        1:       m_if.TREADY = ((tr_idx % 3) == 0);
        default: m_if.TREADY = 1'($urandom_range(0, 1));
      endcase
      tr_idx++;
    end
  end

  // Monitor: records accepted beats and control pulses per cycle.
  initial begin
    beat_t b;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (m_if.TVALID === 1'b1) any_valid = 1'b1;
      if (m_if.TVALID === 1'b1 && m_if.TREADY === 1'b1) begin
        b.data = m_if.TDATA; b.keep = m_if.TKEEP; b.strb = m_if.TSTRB;
        b.last = m_if.TLAST; b.cyc = cyc;
        obs_q.push_back(b);
      end
      if (ap_done === 1'b1)  done_q.push_back(cyc);
      if (ap_ready === 1'b1) ready_q.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_pkt(input int bc, input logic [31:0] s);
    int    nb, rem;
    beat_t b;
    exp_q.delete();
    nb  = (bc + 3) / 4;
    rem = bc % 4;
    for (int k = 0; k < nb; k++) begin
      b.data = s + 32'(k);
      b.keep = (k == nb - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF;
      b.strb = b.keep;
      b.last = (k == nb - 1);
      b.cyc  = 0;
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (ap_idle === 1'b1) break;
      @(negedge ap_clk); #1;
    end
  endtask

  task automatic clear_obs();
    obs_q.delete(); done_q.delete(); ready_q.delete(); any_valid = 1'b0;
  endtask

  task automatic start_pkt(input int bc, input logic [31:0] s);
    @(posedge ap_clk); #1;
    ap_start = 1'b1; byte_count = 16'(bc); seed = s;
    @(posedge ap_clk); #1;
    ap_start = 1'b0; byte_count = 16'($urandom); seed = $urandom;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1; ap_start = 1'b0; byte_count = 16'd0; seed = 32'd0;
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if ({m_if.TVALID, m_if.TLAST, ap_done, ap_idle, ap_ready} !== 5'b00010) begin
      errors++;
      $display("FAIL reset_ctrl: valid/last/done/idle/ready=%b required 00010",
               {m_if.TVALID, m_if.TLAST, ap_done, ap_idle, ap_ready});
    end
    checks++;
    if ({m_if.TDATA, m_if.TKEEP, m_if.TSTRB} !== 40'd0) begin
      errors++;
      $display("FAIL reset_data: data=%h keep=%h strb=%h required all zero",
               m_if.TDATA, m_if.TKEEP, m_if.TSTRB);
    end
    checks++;
    if (pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_pkt_count: got %0d required 0", pkt_count);
    end
    ap_rst = 1'b0;
    @(negedge ap_clk); #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || m_if.TVALID !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: idle=%b done=%b valid=%b required 1 0 0",
               ap_idle, ap_done, m_if.TVALID);
    end
  endtask

  task automatic test_packet(input string name, input int bc, input logic [31:0] s, input int mode);
    int          nb;
    bit          got;
    logic        pv, pr, pl;
    logic [31:0] pd;
    logic [3:0]  pk;
    tr_mode = mode;
    wait_idle();
    clear_obs();
    model_pkt(bc, s);
    exp_pkts = exp_pkts + 16'd1;
    nb = (bc + 3) / 4;
    start_pkt(bc, s);
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; pk = '0; got = 1'b0;
    for (int i = 0; i < 16 * nb + 40; i++) begin
      @(negedge ap_clk); #1;
      if (pv && !pr) begin
        checks++;
        if (m_if.TVALID !== 1'b1 || m_if.TDATA !== pd || m_if.TKEEP !== pk || m_if.TLAST !== pl) begin
          errors++;
          $display("FAIL %s stall_hold: valid=%b data=%h keep=%h last=%b required 1 %h %h %b",
                   name, m_if.TVALID, m_if.TDATA, m_if.TKEEP, m_if.TLAST, pd, pk, pl);
        end
      end
      pv = m_if.TVALID; pr = m_if.TREADY; pd = m_if.TDATA; pk = m_if.TKEEP; pl = m_if.TLAST;
      if (done_q.size() > 0) begin got = 1'b1; break; end
    end
    @(negedge ap_clk); #1;
    checks++;
    if (!got) begin errors++; $display("FAIL %s done_timeout: no ap_done seen, required one", name); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s beat_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].data !== exp_q[k].data) begin
        errors++;
        $display("FAIL %s beat%0d_data: got %h required %h", name, k, obs_q[k].data, exp_q[k].data);
      end
      checks++;
      if ({obs_q[k].keep, obs_q[k].strb, obs_q[k].last} !== {exp_q[k].keep, exp_q[k].strb, exp_q[k].last}) begin
        errors++;
        $display("FAIL %s beat%0d_qual: keep=%h strb=%h last=%b required %h %h %b", name, k,
                 obs_q[k].keep, obs_q[k].strb, obs_q[k].last, exp_q[k].keep, exp_q[k].strb, exp_q[k].last);
      end
      if (mode == 0 && ready_q.size() > 0) begin
        checks++;
        if (obs_q[k].cyc !== ready_q[0] + 1 + k) begin
          errors++;
          $display("FAIL %s beat%0d_cycle: got %0d required %0d", name, k, obs_q[k].cyc, ready_q[0] + 1 + k);
        end
      end
    end
    checks++;
    if (ready_q.size() !== 1) begin
      errors++;
      $display("FAIL %s ready_pulses: got %0d required 1", name, ready_q.size());
    end
    if (obs_q.size() > 0 && done_q.size() > 0) begin
      checks++;
      if (done_q[0] !== obs_q[obs_q.size() - 1].cyc + 1) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d required %0d", name, done_q[0], obs_q[obs_q.size() - 1].cyc + 1);
      end
    end
    checks++;
    if (done_q.size() !== 1 || pkt_count !== exp_pkts) begin
      errors++;
      $display("FAIL %s done_count: pulses=%0d pkt_count=%0d required 1 %0d", name, done_q.size(), pkt_count, exp_pkts);
    end
  endtask

  task automatic test_empty();
    bit got;
    tr_mode = 0;
    wait_idle();
    clear_obs();
    exp_pkts = exp_pkts + 16'd1;
    start_pkt(0, $urandom);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk); #1;
      if (done_q.size() > 0) begin got = 1'b1; break; end
    end
    repeat (3) begin @(negedge ap_clk); #1; end
    checks++;
    if (!got) begin errors++; $display("FAIL empty_done: no ap_done seen, required one"); end
    checks++;
    if (any_valid !== 1'b0 || obs_q.size() !== 0) begin
      errors++;
      $display("FAIL empty_no_beat: valid_seen=%b beats=%0d required 0 0", any_valid, obs_q.size());
    end
    checks++;
    if (ready_q.size() !== 1 || done_q.size() !== 1) begin
      errors++;
      $display("FAIL empty_pulses: ready=%0d done=%0d required 1 1", ready_q.size(), done_q.size());
    end
    if (ready_q.size() > 0 && done_q.size() > 0) begin
      checks++;
      if (done_q[0] !== ready_q[0] + 1) begin
        errors++;
        $display("FAIL empty_done_cycle: got %0d required %0d", done_q[0], ready_q[0] + 1);
      end
    end
    checks++;
    if (pkt_count !== exp_pkts || ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL empty_count: pkt_count=%0d idle=%b required %0d 1", pkt_count, ap_idle, exp_pkts);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    int n;
    tr_mode = 0;
    wait_idle();
    clear_obs();
    start_pkt(20, $urandom);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk); #1;
      if (obs_q.size() >= 2) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin errors++; $display("FAIL rst_mid_progress: beats=%0d required 2", obs_q.size()); end
    @(posedge ap_clk); #1;
    checks++;
    if (m_if.TVALID !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_beat2_valid: got %b required 1", m_if.TVALID);
    end
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    exp_pkts = 16'd0;
    checks++;
    if ({m_if.TVALID, m_if.TLAST, m_if.TKEEP, ap_idle, ap_done} !== 8'b00_0000_10 || pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_state: valid=%b last=%b keep=%h idle=%b done=%b pkt_count=%0d required 0 0 0 1 0 0",
               m_if.TVALID, m_if.TLAST, m_if.TKEEP, ap_idle, ap_done, pkt_count);
    end
    n = obs_q.size();
    repeat (4) begin @(negedge ap_clk); #1; end
    checks++;
    if (obs_q.size() !== n || done_q.size() !== 0 || m_if.TVALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_abandon: beats=%0d done=%0d valid=%b required %0d 0 0",
               obs_q.size(), done_q.size(), m_if.TVALID, n);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    bit          got;
    tr_mode = 0;
    wait_idle();
    clear_obs();
    s = $urandom;
    @(posedge ap_clk); #1;
    ap_start = 1'b1; byte_count = 16'd4; seed = s;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ap_clk); #1;
      if (done_q.size() >= 3) begin got = 1'b1; break; end
    end
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (3) begin @(negedge ap_clk); #1; end
    exp_pkts = exp_pkts + 16'd3;
    checks++;
    if (!got) begin errors++; $display("FAIL b2b_timeout: done pulses=%0d required 3", done_q.size()); end
    checks++;
    if (obs_q.size() !== 3 || ready_q.size() !== 3 || done_q.size() !== 3) begin
      errors++;
      $display("FAIL b2b_counts: beats=%0d ready=%0d done=%0d required 3 3 3",
               obs_q.size(), ready_q.size(), done_q.size());
    end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].data, obs_q[i].keep, obs_q[i].last} !== {s, 4'hF, 1'b1}) begin
        errors++;
        $display("FAIL b2b_beat%0d: data=%h keep=%h last=%b required %h f 1",
                 i, obs_q[i].data, obs_q[i].keep, obs_q[i].last, s);
      end
      if (i < done_q.size()) begin
        checks++;
        if (done_q[i] !== obs_q[i].cyc + 1) begin
          errors++;
          $display("FAIL b2b_done%0d_cycle: got %0d required %0d", i, done_q[i], obs_q[i].cyc + 1);
        end
      end
      if (i < 2 && i + 1 < obs_q.size() && i + 1 < ready_q.size()) begin
        checks++;
        if (ready_q[i + 1] !== obs_q[i].cyc + 2 || obs_q[i + 1].cyc !== obs_q[i].cyc + 3) begin
          errors++;
          $display("FAIL b2b_gap%0d: ready=%0d next_beat=%0d required %0d %0d", i,
                   ready_q[i + 1], obs_q[i + 1].cyc, obs_q[i].cyc + 2, obs_q[i].cyc + 3);
        end
      end
    end
    checks++;
    if (pkt_count !== exp_pkts || ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pkt_count: got %0d idle=%b required %0d 1", pkt_count, ap_idle, exp_pkts);
    end
  endtask

  initial begin
    test_reset();
    test_packet("basic12", 12, 32'h0000_0010, 0);
    test_packet("wrap6", 6, 32'hFFFF_FFFF, 0);
    test_packet("stall16", 16, $urandom, 1);
    test_empty();
    for (int r = 0; r < 4; r++)
      test_packet("rand", $urandom_range(1, 40), $urandom, 2);
    test_reset_mid();
    test_packet("fresh20", 20, $urandom, 0);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
